debounce_sync: RTL and testbench
================================

# debounce_sync

Input-conditioning stage that sits directly upstream of the registered D flip-flop. It takes an asynchronous, bouncy raw input, synchronises it into `clk`, and qualifies each level change with a stability counter. It drives the clean level `dout` into the flip-flop's `d` input, plus single-cycle edge pulses and a saturating glitch counter for diagnostics.

## Interface
- `SYNC_STAGES`, 2, number of synchroniser flops (≥2)
- `STABLE_CYCLES`, 4, consecutive equal synchronised samples required to accept a new level (≥2, ≤ 2**CNT_W − 1)
- `CNT_W`, 16, stability counter width
- `GLITCH_W`, 8, glitch counter width
- `clk` in 1 — single clock; all state updates on posedge
- `rst` in 1 — synchronous, active-high reset; highest priority
- `din` in 1 — raw asynchronous input
- `glitch_clr` in 1 — synchronous clear of `glitch_cnt`
- `dout` out 1 — debounced level (registered)
- `rise` out 1 — one-cycle pulse on accepted 0→1
- `fall` out 1 — one-cycle pulse on accepted 1→0
- `glitch_cnt` out GLITCH_W — saturating count of aborted transitions

## Operation
- Synchroniser: `sync[0] <= din`, `sync[k] <= sync[k-1]`; `s = sync[SYNC_STAGES-1]`. Only `s` feeds the FSM.
- FSM states: LOW, PEND_H, HIGH, PEND_L. `dout` = 1 in HIGH and PEND_L, and 0 otherwise. It is registered, not decoded.
- LOW: `s`=1 → `cnt<=1`, go to PEND_H; else stay.
- PEND_H:
  - `s`=0 → go to LOW; glitch event.
  - `s`=1 and `cnt==STABLE_CYCLES-1` → go to HIGH, `dout<=1`, `rise<=1`.
  - Else `cnt<=cnt+1`.
- HIGH: `s`=0 → `cnt<=1`, go to PEND_L; else stay.
- PEND_L: mirror of PEND_H. Abort returns to HIGH. Acceptance goes to LOW with `dout<=0`, `fall<=1`.
- `rise` and `fall` are 0 in every cycle not explicitly set. They are never both 1.
- Glitch event: `glitch_cnt <= glitch_cnt+1`, saturating at 2**GLITCH_W − 1 (it holds there and does not wrap).
- `glitch_clr`=1 forces `glitch_cnt<=0` and overrides a same-cycle glitch event (that event is lost).
- `rst`=1 sets:
  - all `sync` flops to 0
  - state to LOW and `cnt` to 0
  - `dout`, `rise`, `fall` to 0
  - `glitch_cnt` to 0
- `rst` overrides all other inputs.
- Reset during PEND_H or PEND_L: the pending transition is discarded, with no pulse and no glitch count.
- `din` held at 1 through reset release: after release it is qualified normally and produces a `rise` pulse.

## Timing
- Count the edge at which `sync[0]` first captures the new `din` as edge 0.
- `s` changes after edge SYNC_STAGES−1. The FSM first samples it at edge SYNC_STAGES.
- `dout` and the edge pulse assert after edge SYNC_STAGES+STABLE_CYCLES−1. With defaults that is edge 5.
- A pulse lasts exactly one cycle and is coincident with the first cycle of the new `dout` level.
- A new level is accepted only after STABLE_CYCLES consecutive FSM samples equal to it. Any differing sample inside the window aborts it.
- Throughput: the minimum spacing between accepted transitions is STABLE_CYCLES cycles.
- The glitch counter updates on the same edge as the abort.

## Test plan
- Reset: `rst`=1 for 3 cycles with `din`=1 → `dout`, `rise`, `fall` and `glitch_cnt` all 0 throughout. After release, with `din` first captured at edge 0, `dout`=1 and `rise`=1 after edge 5, and `rise`=0 after edge 6.
- Clean rise then fall:
  - `din` 0→1 captured at edge 10 → `dout`=1 and `rise`=1 after edge 15 only.
  - `din` 1→0 captured at edge 30 → `dout`=0 and `fall`=1 after edge 35 only.
  - `glitch_cnt` stays 0.
- Short high glitch: `din`=1 only for captures at edges 10–11 → FSM samples `s`=1 at edges 12–13 and `s`=0 at edge 14 → `dout` stays 0, no `rise`, `glitch_cnt`=1 after edge 14.
- Short low glitch from HIGH: `din`=0 for 3 captures then back to 1 → `dout` stays 1, no `fall`, `glitch_cnt` increments by 1.
- Saturation and clear: 260 aborted glitches → `glitch_cnt`=255 and holds. Then `glitch_clr`=1 in the same cycle as an abort → `glitch_cnt`=0.
- Reset mid-pending: assert `rst` on the cycle the FSM is in PEND_H with `cnt`=2 → `dout`=0, no `rise`, `glitch_cnt` unchanged at 0. After release with `din`=1, `rise` follows 5 edges after the first post-reset capture.

Source files
------------

// File: rtl/debounce_sync.sv
// debounce_sync: synchronise a bouncy input and accept level changes only after a stability window
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                glitch_clr,
  output logic                dout,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  typedef enum logic [1:0] {LOW, PEND_H, HIGH, PEND_L} state_t;
  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state, w_state;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic                   r_dout, r_rise, r_fall, w_rise, w_fall, w_glitch, w_s, w_done;
  logic [GLITCH_W-1:0]    r_glitch, w_glitch_nxt;
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_done = r_cnt == CNT_W'(STABLE_CYCLES - 1);
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_rise   = 1'b0;
    w_fall   = 1'b0;
    w_glitch = 1'b0;
    case (r_state)
      LOW: if (w_s) begin
        w_cnt   = CNT_W'(1);
        w_state = PEND_H;
      end
      PEND_H: if (!w_s) begin
        w_state  = LOW;
        w_glitch = 1'b1;
      end else if (w_done) begin
        w_state = HIGH;
        w_rise  = 1'b1;
      end else w_cnt = r_cnt + 1'b1;
      HIGH: if (!w_s) begin
        w_cnt   = CNT_W'(1);
        w_state = PEND_L;
      end
      default: if (w_s) begin
        w_state  = HIGH;
        w_glitch = 1'b1;
      end else if (w_done) begin
        w_state = LOW;
        w_fall  = 1'b1;
      end else w_cnt = r_cnt + 1'b1;
    endcase
    // clear wins over a same-cycle abort; the count holds at all-ones
    w_glitch_nxt = glitch_clr ? '0 : (w_glitch && r_glitch != {GLITCH_W{1'b1}}) ? r_glitch + 1'b1 : r_glitch;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_state  <= LOW;
      r_cnt    <= '0;
      r_dout   <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], din};
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_dout   <= w_state == HIGH || w_state == PEND_L;
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      r_glitch <= w_glitch_nxt;
    end
  end
  assign dout       = r_dout;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign glitch_cnt = r_glitch;
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed checks of synchroniser latency, qualification, glitch counting and reset
module tb_debounce_sync;
  logic       clk, rst, din, glitch_clr, dout, rise, fall;
  logic [7:0] glitch_cnt;
  int         n_chk, n_err;
  debounce_sync dut (
    .clk(clk), .rst(rst), .din(din), .glitch_clr(glitch_clr),
    .dout(dout), .rise(rise), .fall(fall), .glitch_cnt(glitch_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // i counts edges from the first capture of the new din level
  task automatic xfer(input logic v);
    din = v;
    for (int i = 0; i <= 6; i++) begin
      tick();
      chk("xfer_dout", int'(dout), (i >= 5) ? int'(v) : int'(!v));
      chk("xfer_pulse", v ? int'(rise) : int'(fall), int'(i == 5));
      chk("xfer_other", v ? int'(fall) : int'(rise), 0);
    end
  endtask
  task automatic glitch(input logic v, input int len, input int g0);
    din = v;
    for (int i = 0; i <= 7; i++) begin
      if (i == len) din = !v;
      tick();
      chk("glitch_dout", int'(dout), int'(!v));
      chk("glitch_pulse", int'(rise | fall), 0);
      chk("glitch_cnt", int'(glitch_cnt), (i >= len + 2) ? g0 + 1 : g0);
    end
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    din = 1'b1;
    glitch_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_dout", int'(dout), 0);
      chk("rst_pulse", int'(rise | fall), 0);
      chk("rst_glitch", int'(glitch_cnt), 0);
    end
    rst = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      chk("rel_dout", int'(dout), int'(i >= 5));
      chk("rel_rise", int'(rise), int'(i == 5));
    end
    xfer(1'b0);
    xfer(1'b1);
    xfer(1'b0);
    chk("clean_glitch", int'(glitch_cnt), 0);
    glitch(1'b1, 2, 0);
    xfer(1'b1);
    glitch(1'b0, 3, 1);
    for (int k = 0; k < 258; k++) begin
      din = 1'b0;
      tick();
      din = 1'b1;
      repeat (3) tick();
    end
    chk("sat_glitch", int'(glitch_cnt), 255);
    chk("sat_dout", int'(dout), 1);
    din = 1'b0;
    tick();
    din = 1'b1;
    repeat (3) tick();
    chk("sat_hold", int'(glitch_cnt), 255);
    din = 1'b0;
    tick();
    din = 1'b1;
    repeat (2) tick();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    chk("clr_over_abort", int'(glitch_cnt), 0);
    chk("clr_dout", int'(dout), 1);
    xfer(1'b0);
    din = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_rise", int'(rise), 0);
    chk("midrst_glitch", int'(glitch_cnt), 0);
    for (int i = 0; i <= 6; i++) begin
      tick();
      chk("post_dout", int'(dout), int'(i >= 5));
      chk("post_rise", int'(rise), int'(i == 5));
      chk("post_glitch", int'(glitch_cnt), 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
